scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Generalises the fixed 4:16 combinational decoder to any select width.
- Adds a registered output and an autonomous scan mode that walks the one-hot output through every line at a programmable rate.
- Intended for multiplexed display digit/row strobing and round-robin line select. Sits between a control FSM and the strobed lines.

Parameters:
- N, 4, select width; output width is 2^N; legal range 1..6.
- DIV, 4, clock cycles each line is held in scan mode; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  output enable; when 0 all outputs are forced low.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- w  input  N  select value, used in direct mode.
- y  output  2^N  one-hot output, declared [0:2^N-1]; y[k] is active for index k.
- idx  output  N  current selected index (registered).
- wrap  output  1  one-cycle pulse when scan wraps from the last index to 0.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset, sampled on a clk edge with rst=1:
  - y=0, idx=0, wrap=0.
  - Internal divider count cnt=0.
  - rst has priority over all other inputs.
- Invariant: when en=1 in the previous cycle, y == (1 << idx) interpreted in [0:2^N-1] order; otherwise y=0.
- en=0:
  - Next edge: y=0, wrap=0.
  - idx and cnt hold.
- en=1, mode=0 (direct):
  - Next edge: idx<=w, y<=onehot(w), cnt<=0, wrap<=0.
  - Latency is 1 cycle from w to y.
- en=1, mode=1 (scan):
  - cnt counts 0..DIV-1; y<=onehot(idx) every cycle.
  - When cnt==DIV-1: cnt<=0 and idx<=idx+1 modulo 2^N. y shows the new index on the same edge as idx.
  - When cnt<DIV-1: cnt<=cnt+1; idx holds.
  - wrap<=1 only on the edge where idx goes from 2^N-1 to 0; otherwise 0.
  - DIV=1: idx advances every cycle.
- Mode change 0->1: scan resumes from the current idx with cnt=0 (the first line is held for a full DIV cycles).
- Mode change 1->0: the next edge loads w immediately, and the divider is discarded.
- en toggled 0->1 in scan mode: scan resumes at the held idx/cnt. Lines are never skipped.
- rst mid-scan: next state is the reset state; y=0 for that cycle.
- Arithmetic:
  - cnt width is clog2(DIV), minimum 1 bit.
  - idx increment truncates to N bits (natural wrap).
- y is never multi-hot in any cycle.

Optional Feature:
- Macro: SCAN_DECODER_DIR_EN.
- Defined: adds input port dir (1 bit).
  - In scan mode, dir=0 increments idx; dir=1 decrements idx modulo 2^N.
  - When decrementing, wrap pulses on the 0 -> 2^N-1 transition.
  - dir is sampled on the step edge only.
- Not defined: no dir port; scan always increments (behaviour as above).

Test Plan:
- Reset then direct decode (N=4): rst=1 one cycle, then en=1, mode=0, w=4'b1010. One cycle later: y[10]=1 and all other bits 0, idx=10, wrap=0.
- Enable gating: from the above state, set en=0. Next cycle: y=16'h0000 with idx held at 10. Set en=1 with w unchanged: y[10]=1 again after 1 cycle.
- Scan with wrap (N=4, DIV=4): direct-load w=14, then switch mode=1.
  - idx=14 is held 4 cycles, then 15 for 4 cycles, then 0.
  - wrap=1 for exactly the single cycle idx becomes 0.
  - y tracks idx with exactly one bit set throughout.
- DIV=1 full sweep (N=2): scan from idx=0.
  - y steps y[0], y[1], y[2], y[3], y[0] on consecutive cycles.
  - wrap pulses every 4th cycle.
- Mid-scan events (N=4, DIV=4):
  - rst asserted at idx=7, cnt=2: next cycle y=0, idx=0, wrap=0.
  - Separately, mode 1->0 with w=3 at idx=7: next cycle y[3]=1, idx=3.
- With SCAN_DECODER_DIR_EN (N=4, DIV=2): scan from idx=1 with dir=1.
  - idx sequence is 1,1,0,0,15,...
  - wrap pulses on the 0->15 step.

Source files
------------

// File: rtl/scan_decoder_if.sv
// Bus between a control FSM and scan_decoder: decode controls in, strobe lines out.
// The dir signal exists only when SCAN_DECODER_DIR_EN is defined.
interface scan_decoder_if #(
  parameter int N = 4
);
  logic                 en;
  logic                 mode;
  logic [N-1:0]         w;
  logic [0:(1<<N)-1]    y;
  logic [N-1:0]         idx;
  logic                 wrap;
`ifdef SCAN_DECODER_DIR_EN
  logic                 dir;
`endif

  modport master (
`ifdef SCAN_DECODER_DIR_EN
    output dir,
`endif
    output en, mode, w,
    input  y, idx, wrap
  );

  modport slave (
`ifdef SCAN_DECODER_DIR_EN
    input  dir,
`endif
    input  en, mode, w,
    output y, idx, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with an autonomous scan mode that walks the
// output through every line, holding each for DIV cycles. Optional macro SCAN_DECODER_DIR_EN adds scan direction.
module scan_decoder #(
  parameter int N   = 4,
  parameter int DIV = 4
) (
  input logic          clk,
  input logic          rst,
  scan_decoder_if.slave bus
);

  localparam int LINES = 1 << N;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [N-1:0]  IDX_MAX = N'(LINES - 1);

  logic [0:LINES-1] y_q, y_d;
  logic [N-1:0]     idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             step_down;

`ifdef SCAN_DECODER_DIR_EN
  assign step_down = bus.dir;
`else
  assign step_down = 1'b0;
`endif

  // Disabled cycles hold idx/cnt so a resumed scan never skips a line.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    y_d    = '0;
    if (bus.en) begin
      if (!bus.mode) begin
        idx_d = bus.w;
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (step_down) begin
          idx_d  = idx_q - N'(1);
          wrap_d = (idx_q == '0);
        end else begin
          idx_d  = idx_q + N'(1);
          wrap_d = (idx_q == IDX_MAX);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      for (int k = 0; k < LINES; k++) begin
        y_d[k] = (idx_d == N'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder: N=4/DIV=4 and N=2/DIV=1 instances,
// plus an N=4/DIV=2 down-scan instance when SCAN_DECODER_DIR_EN is defined.
module tb_scan_decoder;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  scan_decoder_if #(.N(4)) if0 ();
  scan_decoder_if #(.N(2)) if1 ();

  scan_decoder #(.N(4), .DIV(4)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  scan_decoder #(.N(2), .DIV(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

`ifdef SCAN_DECODER_DIR_EN
  scan_decoder_if #(.N(4)) if2 ();
  scan_decoder #(.N(4), .DIV(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line k of a [0:15] vector is bit 15-k of its numeric value.
  function automatic logic [15:0] oh4(input int k);
    return 16'h8000 >> k;
  endfunction

  function automatic logic [3:0] oh2(input int k);
    return 4'h8 >> k;
  endfunction

  int scanIdx4 [8] = '{14, 14, 14, 15, 15, 15, 15, 0};
  int scanWrp4 [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  int sweepIdx [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int sweepWrp [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    if0.en = 1'b0; if0.mode = 1'b0; if0.w = '0;
    if1.en = 1'b0; if1.mode = 1'b0; if1.w = '0;
`ifdef SCAN_DECODER_DIR_EN
    if0.dir = 1'b0; if1.dir = 1'b0;
    if2.en = 1'b0; if2.mode = 1'b0; if2.w = '0; if2.dir = 1'b0;
`endif
    #2;
    tick();
    checkOutput("rst_y", 64'(if0.y), 64'h0);
    checkOutput("rst_idx", 64'(if0.idx), 64'd0);
    checkOutput("rst_wrap", 64'(if0.wrap), 64'd0);

    rst = 1'b0;
    if0.en = 1'b1; if0.w = 4'b1010;
    tick();
    checkOutput("dir_y", 64'(if0.y), 64'(oh4(10)));
    checkOutput("dir_y10", 64'(if0.y[10]), 64'd1);
    checkOutput("dir_idx", 64'(if0.idx), 64'd10);
    checkOutput("dir_wrap", 64'(if0.wrap), 64'd0);

    if0.en = 1'b0;
    tick();
    checkOutput("gate_y", 64'(if0.y), 64'h0);
    checkOutput("gate_idx", 64'(if0.idx), 64'd10);
    if0.en = 1'b1;
    tick();
    checkOutput("regate_y", 64'(if0.y), 64'(oh4(10)));

    if0.w = 4'd14;
    tick();
    checkOutput("load14_idx", 64'(if0.idx), 64'd14);
    if0.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("scan_idx%0d", i), 64'(if0.idx), 64'(scanIdx4[i]));
      checkOutput($sformatf("scan_y%0d", i), 64'(if0.y), 64'(oh4(scanIdx4[i])));
      checkOutput($sformatf("scan_wrap%0d", i), 64'(if0.wrap), 64'(scanWrp4[i]));
    end
    tick();
    checkOutput("postwrap_wrap", 64'(if0.wrap), 64'd0);

    // Mid-scan reset at idx=7, cnt=2
    if0.mode = 1'b0; if0.w = 4'd7;
    tick();
    if0.mode = 1'b1;
    tick();
    tick();
    checkOutput("pre_rst_idx", 64'(if0.idx), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_y", 64'(if0.y), 64'h0);
    checkOutput("midrst_idx", 64'(if0.idx), 64'd0);
    checkOutput("midrst_wrap", 64'(if0.wrap), 64'd0);

    // Scan to direct switch loads w immediately
    if0.mode = 1'b0; if0.w = 4'd7;
    tick();
    if0.mode = 1'b1;
    tick();
    if0.mode = 1'b0; if0.w = 4'd3;
    tick();
    checkOutput("m10_y", 64'(if0.y), 64'(oh4(3)));
    checkOutput("m10_idx", 64'(if0.idx), 64'd3);

    // en toggle mid-scan keeps idx and cnt
    if0.w = 4'd5;
    tick();
    if0.mode = 1'b1;
    tick();
    if0.en = 1'b0;
    tick();
    checkOutput("scanoff_y", 64'(if0.y), 64'h0);
    checkOutput("scanoff_idx", 64'(if0.idx), 64'd5);
    if0.en = 1'b1;
    tick();
    checkOutput("scanon_y", 64'(if0.y), 64'(oh4(5)));
    tick();
    checkOutput("scanon_hold", 64'(if0.idx), 64'd5);
    tick();
    checkOutput("scanon_step", 64'(if0.idx), 64'd6);

    // DIV=1 sweep on the N=2 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if1.en = 1'b1; if1.mode = 1'b0; if1.w = 2'd0;
    tick();
    checkOutput("sw_start_y", 64'(if1.y), 64'(oh2(0)));
    if1.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("sw_idx%0d", i), 64'(if1.idx), 64'(sweepIdx[i]));
      checkOutput($sformatf("sw_y%0d", i), 64'(if1.y), 64'(oh2(sweepIdx[i])));
      checkOutput($sformatf("sw_wrap%0d", i), 64'(if1.wrap), 64'(sweepWrp[i]));
    end

`ifdef SCAN_DECODER_DIR_EN
    begin
      int downIdx [4] = '{1, 0, 0, 15};
      int downWrp [4] = '{0, 0, 0, 1};
      if2.en = 1'b1; if2.mode = 1'b0; if2.w = 4'd1;
      tick();
      checkOutput("dn_load", 64'(if2.idx), 64'd1);
      if2.mode = 1'b1; if2.dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        checkOutput($sformatf("dn_idx%0d", i), 64'(if2.idx), 64'(downIdx[i]));
        checkOutput($sformatf("dn_y%0d", i), 64'(if2.y), 64'(oh4(downIdx[i])));
        checkOutput($sformatf("dn_wrap%0d", i), 64'(if2.wrap), 64'(downWrp[i]));
      end
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
